// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module   : stopwatch_pkg
// Purpose  : Shared state encodings and default widths for the stopwatch
//            control block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam int SW_TIME_W    = 7;
    localparam int SW_LAP_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_REVIEW = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_event.sv
// ============================================================================
// Module   : btn_event
// Purpose  : Turns a raw active-high push-button into a single one-cycle
//            event once it has been seen high for DEB_CYCLES edges.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event #(
    parameter int DEB_CYCLES = 2
) (
    input  logic clk100Hz,
    input  logic reset,
    input  logic btn,
    output logic evt
);

    localparam logic [3:0] C_DEB = 4'(DEB_CYCLES);

    logic [3:0] r_cnt;
    logic       r_evt;

    // Counter saturates at C_DEB so a held button fires only once.
    always_ff @(posedge clk100Hz or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_evt <= 1'b0;
        end else if (!btn) begin
            r_cnt <= '0;
            r_evt <= 1'b0;
        end else if (r_cnt != C_DEB) begin
            r_cnt <= r_cnt + 4'd1;
            r_evt <= ((r_cnt + 4'd1) == C_DEB);
        end else begin
            r_evt <= 1'b0;
        end
    end

    assign evt = r_evt;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Stopwatch control FSM: button events, run/clear control of the
//            counter core, lap register bank and display mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH  = SW_LAP_DEPTH,
    parameter int DEB_CYCLES = 2,
    parameter int TIME_W     = SW_TIME_W
) (
    input  logic              clk100Hz,
    input  logic              reset,
    input  logic              btn_start_stop,
    input  logic              btn_lap,
    input  logic              btn_clear,
    input  logic [TIME_W-1:0] live_sec,
    input  logic [TIME_W-1:0] live_msec,
    output logic              run_en,
    output logic              clear_req,
    output logic [TIME_W-1:0] disp_sec,
    output logic [TIME_W-1:0] disp_msec,
    output logic [3:0]        lap_count,
    output logic [2:0]        view_idx,
    output logic              lap_full,
    output logic [1:0]        state
);

    localparam int         IDX_W   = $clog2(LAP_DEPTH);
    localparam logic [3:0] C_DEPTH = 4'(LAP_DEPTH);

    logic w_evt_ss;
    logic w_evt_lap;
    logic w_evt_clr;

    btn_event #(.DEB_CYCLES(DEB_CYCLES)) u_evt_ss (
        .clk100Hz (clk100Hz),
        .reset    (reset),
        .btn      (btn_start_stop),
        .evt      (w_evt_ss)
    );

    btn_event #(.DEB_CYCLES(DEB_CYCLES)) u_evt_lap (
        .clk100Hz (clk100Hz),
        .reset    (reset),
        .btn      (btn_lap),
        .evt      (w_evt_lap)
    );

    btn_event #(.DEB_CYCLES(DEB_CYCLES)) u_evt_clr (
        .clk100Hz (clk100Hz),
        .reset    (reset),
        .btn      (btn_clear),
        .evt      (w_evt_clr)
    );

    // Lower-priority events coinciding with a higher one are discarded.
    logic w_clr;
    logic w_ss;
    logic w_lap;

    assign w_clr = w_evt_clr;
    assign w_ss  = w_evt_ss & ~w_evt_clr;
    assign w_lap = w_evt_lap & ~w_evt_ss & ~w_evt_clr;

    state_t            r_state;
    state_t            r_ret;
    logic              r_run_en;
    logic              r_clear_req;
    logic [3:0]        r_lap_count;
    logic [2:0]        r_view_idx;
    logic [TIME_W-1:0] r_lap_sec  [LAP_DEPTH];
    logic [TIME_W-1:0] r_lap_msec [LAP_DEPTH];

    state_t            w_state_nxt;
    state_t            w_ret_nxt;
    logic [3:0]        w_lap_count_nxt;
    logic [2:0]        w_view_idx_nxt;
    logic              w_capture;
    logic              w_clear;

    always_comb begin
        w_state_nxt     = r_state;
        w_ret_nxt       = r_ret;
        w_lap_count_nxt = r_lap_count;
        w_view_idx_nxt  = r_view_idx;
        w_capture       = 1'b0;
        w_clear         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_clr) begin
                    w_clear = 1'b1;
                end else if (w_ss) begin
                    w_state_nxt = ST_RUN;
                end else if (w_lap && (r_lap_count != 4'd0)) begin
                    w_state_nxt    = ST_REVIEW;
                    w_ret_nxt      = ST_IDLE;
                    w_view_idx_nxt = 3'd0;
                end
            end
            ST_RUN: begin
                if (w_ss) begin
                    w_state_nxt = ST_PAUSE;
                end else if (w_lap && (r_lap_count < C_DEPTH)) begin
                    w_capture       = 1'b1;
                    w_lap_count_nxt = r_lap_count + 4'd1;
                end
            end
            ST_PAUSE: begin
                if (w_clr) begin
                    w_state_nxt     = ST_IDLE;
                    w_clear         = 1'b1;
                    w_lap_count_nxt = 4'd0;
                end else if (w_ss) begin
                    w_state_nxt = ST_RUN;
                end else if (w_lap && (r_lap_count != 4'd0)) begin
                    w_state_nxt    = ST_REVIEW;
                    w_ret_nxt      = ST_PAUSE;
                    w_view_idx_nxt = 3'd0;
                end
            end
            ST_REVIEW: begin
                if (w_clr) begin
                    w_state_nxt     = ST_IDLE;
                    w_clear         = 1'b1;
                    w_lap_count_nxt = 4'd0;
                    w_view_idx_nxt  = 3'd0;
                end else if (w_ss) begin
                    w_state_nxt    = r_ret;
                    w_view_idx_nxt = 3'd0;
                end else if (w_lap) begin
                    // Wrap after the last valid lap so stale entries stay hidden.
                    if (({1'b0, r_view_idx} + 4'd1) >= r_lap_count) begin
                        w_view_idx_nxt = 3'd0;
                    end else begin
                        w_view_idx_nxt = r_view_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk100Hz or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ret       <= ST_IDLE;
            r_run_en    <= 1'b0;
            r_clear_req <= 1'b0;
            r_lap_count <= 4'd0;
            r_view_idx  <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ret       <= w_ret_nxt;
            r_run_en    <= (w_state_nxt == ST_RUN);
            r_clear_req <= w_clear;
            r_lap_count <= w_lap_count_nxt;
            r_view_idx  <= w_view_idx_nxt;
        end
    end

    always_ff @(posedge clk100Hz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                r_lap_sec[i]  <= '0;
                r_lap_msec[i] <= '0;
            end
        end else if (w_capture) begin
            r_lap_sec[r_lap_count[IDX_W-1:0]]  <= live_sec;
            r_lap_msec[r_lap_count[IDX_W-1:0]] <= live_msec;
        end
    end

    always_comb begin
        disp_sec  = live_sec;
        disp_msec = live_msec;
        if (r_state == ST_REVIEW) begin
            disp_sec  = r_lap_sec[r_view_idx[IDX_W-1:0]];
            disp_msec = r_lap_msec[r_view_idx[IDX_W-1:0]];
        end
    end

    assign run_en    = r_run_en;
    assign clear_req = r_clear_req;
    assign lap_count = r_lap_count;
    assign view_idx  = r_view_idx;
    assign lap_full  = (r_lap_count == C_DEPTH);
    assign state     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Directed self-checking bench for stopwatch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    logic       clk100Hz;
    logic       reset;
    logic       btn_start_stop;
    logic       btn_lap;
    logic       btn_clear;
    logic [6:0] live_sec;
    logic [6:0] live_msec;
    logic       run_en;
    logic       clear_req;
    logic [6:0] disp_sec;
    logic [6:0] disp_msec;
    logic [3:0] lap_count;
    logic [2:0] view_idx;
    logic       lap_full;
    logic [1:0] state;

    int n_cmp = 0;
    int n_err = 0;

    stopwatch_ctrl dut (
        .clk100Hz       (clk100Hz),
        .reset          (reset),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .live_sec       (live_sec),
        .live_msec      (live_msec),
        .run_en         (run_en),
        .clear_req      (clear_req),
        .disp_sec       (disp_sec),
        .disp_msec      (disp_msec),
        .lap_count      (lap_count),
        .view_idx       (view_idx),
        .lap_full       (lap_full),
        .state          (state)
    );

    initial clk100Hz = 1'b0;
    always #5 clk100Hz = ~clk100Hz;

    typedef struct {
        logic ss, lap, clr;
        int   sec, msec;
        int   st, run, creq, lc, full, view, dsec, dmsec;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ss, input logic lap, input logic clr,
                       input int sec, input int msec, input int st, input int run,
                       input int creq, input int lc, input int full, input int view,
                       input int dsec, input int dmsec);
        vec_t v;
        v.ss = ss; v.lap = lap; v.clr = clr; v.sec = sec; v.msec = msec;
        v.st = st; v.run = run; v.creq = creq; v.lc = lc; v.full = full;
        v.view = view; v.dsec = dsec; v.dmsec = dmsec;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int run, input int creq,
                           input int lc, input int full, input int view,
                           input int dsec, input int dmsec);
        chk({tag, ".state"},     int'(state),     st);
        chk({tag, ".run_en"},    int'(run_en),    run);
        chk({tag, ".clear_req"}, int'(clear_req), creq);
        chk({tag, ".lap_count"}, int'(lap_count), lc);
        chk({tag, ".lap_full"},  int'(lap_full),  full);
        chk({tag, ".view_idx"},  int'(view_idx),  view);
        chk({tag, ".disp_sec"},  int'(disp_sec),  dsec);
        chk({tag, ".disp_msec"}, int'(disp_msec), dmsec);
    endtask

    // One clock edge; inputs are driven and outputs sampled 1 ns after it.
    task automatic step();
        @(posedge clk100Hz);
        #1;
    endtask

    // which: 0 = start/stop, 1 = lap, 2 = clear. Action lands on the 3rd edge.
    task automatic press(input int which, input int s, input int m);
        live_sec  = 7'(s);
        live_msec = 7'(m);
        btn_start_stop = (which == 0);
        btn_lap        = (which == 1);
        btn_clear      = (which == 2);
        step();
        step();
        btn_start_stop = 1'b0;
        btn_lap        = 1'b0;
        btn_clear      = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b0;
        btn_start_stop = 1'b0;
        btn_lap = 1'b0;
        btn_clear = 1'b0;
        live_sec = 7'd5;
        live_msec = 7'd6;

        //   ss lap clr sec msec | st run creq lc full view dsec dmsec
        for (int i = 0; i < 2; i++) add(1, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0,  0,  0);
        for (int i = 0; i < 3; i++) add(1, 0, 0,  0,  0, 1, 1, 0, 0, 0, 0,  0,  0);
        add(0, 0, 0,  0,  0, 1, 1, 0, 0, 0, 0,  0,  0);
        add(0, 1, 0,  3, 27, 1, 1, 0, 0, 0, 0,  3, 27);
        add(0, 1, 0,  3, 27, 1, 1, 0, 0, 0, 0,  3, 27);
        add(0, 0, 0,  3, 27, 1, 1, 0, 1, 0, 0,  3, 27);
        add(0, 1, 0,  7,  5, 1, 1, 0, 1, 0, 0,  7,  5);
        add(0, 1, 0,  7,  5, 1, 1, 0, 1, 0, 0,  7,  5);
        add(0, 0, 0,  7,  5, 1, 1, 0, 2, 0, 0,  7,  5);
        add(0, 1, 0,  9,  9, 1, 1, 0, 2, 0, 0,  9,  9);
        add(0, 1, 0,  9,  9, 1, 1, 0, 2, 0, 0,  9,  9);
        add(0, 0, 0,  9,  9, 1, 1, 0, 3, 0, 0,  9,  9);
        add(0, 1, 0, 12, 34, 1, 1, 0, 3, 0, 0, 12, 34);
        add(0, 1, 0, 12, 34, 1, 1, 0, 3, 0, 0, 12, 34);
        add(0, 0, 0, 12, 34, 1, 1, 0, 4, 1, 0, 12, 34);
        add(0, 1, 0, 50, 50, 1, 1, 0, 4, 1, 0, 50, 50);
        add(0, 1, 0, 50, 50, 1, 1, 0, 4, 1, 0, 50, 50);
        add(0, 0, 0, 50, 50, 1, 1, 0, 4, 1, 0, 50, 50);
        add(1, 0, 0, 50, 50, 1, 1, 0, 4, 1, 0, 50, 50);
        add(1, 0, 0, 50, 50, 1, 1, 0, 4, 1, 0, 50, 50);
        add(0, 0, 0, 50, 50, 2, 0, 0, 4, 1, 0, 50, 50);
        add(0, 1, 0, 50, 50, 2, 0, 0, 4, 1, 0, 50, 50);
        add(0, 1, 0, 50, 50, 2, 0, 0, 4, 1, 0, 50, 50);
        add(0, 0, 0, 50, 50, 3, 0, 0, 4, 1, 0,  3, 27);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 0,  3, 27);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 0,  3, 27);
        add(0, 0, 0, 50, 50, 3, 0, 0, 4, 1, 1,  7,  5);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 1,  7,  5);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 1,  7,  5);
        add(0, 0, 0, 50, 50, 3, 0, 0, 4, 1, 2,  9,  9);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 2,  9,  9);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 2,  9,  9);
        add(0, 0, 0, 50, 50, 3, 0, 0, 4, 1, 3, 12, 34);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 3, 12, 34);
        add(0, 1, 0, 50, 50, 3, 0, 0, 4, 1, 3, 12, 34);
        add(0, 0, 0, 50, 50, 3, 0, 0, 4, 1, 0,  3, 27);
        add(1, 0, 0, 50, 50, 3, 0, 0, 4, 1, 0,  3, 27);
        add(1, 0, 0, 50, 50, 3, 0, 0, 4, 1, 0,  3, 27);
        add(0, 0, 0, 50, 50, 2, 0, 0, 4, 1, 0, 50, 50);
        add(1, 0, 1, 50, 50, 2, 0, 0, 4, 1, 0, 50, 50);
        add(1, 0, 1, 50, 50, 2, 0, 0, 4, 1, 0, 50, 50);
        add(0, 0, 0, 50, 50, 0, 0, 1, 0, 0, 0, 50, 50);
        add(0, 0, 0, 50, 50, 0, 0, 0, 0, 0, 0, 50, 50);
        add(0, 1, 0, 50, 50, 0, 0, 0, 0, 0, 0, 50, 50);
        add(0, 1, 0, 50, 50, 0, 0, 0, 0, 0, 0, 50, 50);
        add(0, 0, 0, 50, 50, 0, 0, 0, 0, 0, 0, 50, 50);

        // Reset state, display following live inputs.
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 5, 6);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_start_stop = vecs[i].ss;
            btn_lap        = vecs[i].lap;
            btn_clear      = vecs[i].clr;
            live_sec       = 7'(vecs[i].sec);
            live_msec      = 7'(vecs[i].msec);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].run, vecs[i].creq,
                    vecs[i].lc, vecs[i].full, vecs[i].view, vecs[i].dsec, vecs[i].dmsec);
        end

        // Three laps, pause, browse with wrap after the third lap.
        press(0, 0, 0);
        chk_all("seq.run", 1, 1, 0, 0, 0, 0, 0, 0);
        press(1, 1, 11);
        press(1, 2, 22);
        press(1, 3, 33);
        chk_all("seq.laps", 1, 1, 0, 3, 0, 0, 3, 33);
        press(0, 3, 33);
        chk_all("seq.pause", 2, 0, 0, 3, 0, 0, 3, 33);
        press(1, 60, 1);
        chk_all("seq.rev0", 3, 0, 0, 3, 0, 0, 1, 11);
        press(1, 60, 1);
        chk_all("seq.rev1", 3, 0, 0, 3, 0, 1, 2, 22);
        press(1, 60, 1);
        chk_all("seq.rev2", 3, 0, 0, 3, 0, 2, 3, 33);
        press(1, 60, 1);
        chk_all("seq.wrap", 3, 0, 0, 3, 0, 0, 1, 11);
        press(0, 60, 1);
        chk_all("seq.back", 2, 0, 0, 3, 0, 0, 60, 1);
        press(0, 61, 2);
        chk_all("seq.rerun", 1, 1, 0, 3, 0, 0, 61, 2);

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 61, 2);
        step();
        reset = 1'b1;
        step();
        chk_all("post_rst", 0, 0, 0, 0, 0, 0, 61, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM that sequences the stopwatch counter core from three raw push-buttons: start/stop, lap and clear.
- Produces the core's run enable and a synchronous clear request.
- Captures up to LAP_DEPTH lap times into a local register bank.
- Muxes live or stored lap time onto the display path feeding the 7-segment driver.

Parameters:
- LAP_DEPTH, 4, number of lap registers (2..8).
- DEB_CYCLES, 2, consecutive high samples required before a button press is accepted (1..15).
- TIME_W, 7, width of each seconds / hundredths field.

Ports:
- clk100Hz  input  1  100 Hz system tick clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset); release synchronised externally.
- btn_start_stop  input  1  raw start/stop button, active-high.
- btn_lap  input  1  raw lap/browse button, active-high.
- btn_clear  input  1  raw clear button, active-high.
- live_sec  input  TIME_W  current seconds from the stopwatch core.
- live_msec  input  TIME_W  current hundredths from the stopwatch core.
- run_en  output  1  counting enable to the core.
- clear_req  output  1  one-cycle pulse; the core zeroes its count.
- disp_sec  output  TIME_W  seconds to display.
- disp_msec  output  TIME_W  hundredths to display.
- lap_count  output  4  number of valid laps stored (0..LAP_DEPTH).
- view_idx  output  3  lap index currently displayed in REVIEW.
- lap_full  output  1  high while lap_count == LAP_DEPTH.
- state  output  2  FSM state, for debug LEDs.

Behaviour:
- Reset (reset = 0, asynchronous) forces:
  - state = IDLE; run_en = 0; clear_req = 0.
  - lap_count = 0; view_idx = 0; all lap registers = 0; return state = IDLE.
  - disp_* follow live_* combinationally.
- Button event generation, per button:
  - Each button has a saturating high-counter.
  - A one-cycle event is registered on the edge where the counter reaches DEB_CYCLES.
  - The counter clears whenever the button samples low.
  - One event per press; holding a button produces nothing further.
  - The FSM acts on the following edge, so the action takes effect DEB_CYCLES edges after the first high sample (2 edges at default).
- Event priority within a cycle: clear > start_stop > lap. Lower-priority simultaneous events are dropped, not queued.
- States are IDLE=0, RUN=1, PAUSE=2, REVIEW=3.
- IDLE:
  - start_stop -> RUN.
  - lap -> REVIEW if lap_count > 0 (return = IDLE, view_idx = 0); otherwise ignored.
  - clear -> stay IDLE and pulse clear_req.
- RUN:
  - run_en = 1.
  - start_stop -> PAUSE.
  - lap -> if lap_count < LAP_DEPTH, capture {live_sec, live_msec} into lap[lap_count] on that edge and increment lap_count; else drop it (lap_full already high). State unchanged.
  - clear -> ignored.
- PAUSE:
  - start_stop -> RUN.
  - clear -> IDLE; clear_req pulses; lap_count = 0.
  - lap -> REVIEW if lap_count > 0 (return = PAUSE, view_idx = 0).
- REVIEW:
  - run_en = 0.
  - lap -> view_idx increments, wrapping from lap_count-1 to 0.
  - start_stop -> return state; view_idx = 0.
  - clear -> IDLE; clear_req pulses; lap_count = 0; view_idx = 0.
- run_en is registered and equals (state == RUN).
- clear_req is registered and high exactly one cycle, on the edge the clear is accepted.
- Display:
  - disp_* = lap[view_idx] in REVIEW; otherwise live_*. Combinational mux.
  - Stale lap registers beyond lap_count are never displayed.
- Reset mid-operation aborts everything immediately; the core is cleared separately by its own reset.

Decomposition:
- Shared package stopwatch_pkg holds:
  - State encodings ST_IDLE / ST_RUN / ST_PAUSE / ST_REVIEW.
  - TIME_W.
  - LAP_DEPTH default.
- One sub-module, btn_event (DEB_CYCLES parameter; clk100Hz, reset, btn in, evt out), instantiated three times.
- The lap bank and FSM stay in stopwatch_ctrl.

Test Plan:
- Reset, then hold btn_start_stop high 5 cycles -> exactly one event; state = RUN and run_en = 1 two edges after the first high sample; no second toggle while held.
- In RUN, press lap with live time = 3.27 then 7.05 -> lap_count = 2, lap[0] = {3,27}, lap[1] = {7,5}; state stays RUN.
- In RUN, 5 lap presses with LAP_DEPTH = 4 -> lap_count saturates at 4, lap_full = 1, fifth capture dropped, lap[3] unchanged.
- PAUSE with 3 laps: lap press enters REVIEW; 3 further lap presses -> view_idx steps 1, 2, 0 and disp_* tracks the stored laps; start_stop -> PAUSE with disp_* = live.
- Assert btn_clear and btn_start_stop in the same cycle during PAUSE -> clear wins: state = IDLE, one-cycle clear_req, lap_count = 0, state not RUN.
- Pulse reset low for 1 cycle during RUN with 2 laps stored -> run_en = 0, state = IDLE, lap_count = 0 immediately, without waiting for a clock edge.
